// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DATA_W / ADDR_W : default memory word and address widths
//   pri_t           : which requester currently wins contention
//   owner_t         : who owns the read data returning next cycle
package mem_port_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef enum logic {CPU_PRI, DBG_PRI} pri_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data memory between the memory
// stage (normal priority) and a debug/loader port. A starvation counter
// promotes the debug port after STARVE_LIMIT consecutive denied cycles.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i memory-stage request
//   cpu_gnt_o, cpu_stall_o        grant / stall to hazard logic
//   cpu_rvalid_o, cpu_rdata_o     read return to memory stage
//   dbg_req_i/we_i/addr_i/wdata_i debug request
//   dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  data memory side
module mem_port_arbiter #(
  parameter int DATA_W       = mem_port_arbiter_pkg::DATA_W,
  parameter int ADDR_W       = mem_port_arbiter_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  pri_t             pri_q, pri_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_t           owner_q, owner_d;
  logic             cpu_gnt, dbg_gnt;

  // Priority state and starvation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pri_q      <= CPU_PRI;
      wait_cnt_q <= '0;
    end else begin
      pri_q      <= pri_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    pri_d      = pri_q;
    if (dbg_gnt || !dbg_req_i)  wait_cnt_d = '0;
    else if (wait_cnt_q != LIMIT) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    case (pri_q)
      CPU_PRI: if (wait_cnt_d == LIMIT)       pri_d = DBG_PRI;
      DBG_PRI: if (dbg_gnt || !dbg_req_i)     pri_d = CPU_PRI;
      default:                                pri_d = CPU_PRI;
    endcase
  end

  // Grants are gated by reset so nothing touches memory while held in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_ni) begin
      if (pri_q == CPU_PRI) begin
        cpu_gnt = cpu_req_i;
        dbg_gnt = dbg_req_i & ~cpu_req_i;
      end else begin
        dbg_gnt = dbg_req_i;
        cpu_gnt = cpu_req_i & ~dbg_req_i;
      end
    end
  end

  // Memory drive from whichever side won; idle drives zeros.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (dbg_gnt) begin
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end
  end

  // Read owner: tags the memory's one-cycle-late data with its consumer.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we_i)      owner_d = OWN_CPU;
    else if (dbg_gnt && !dbg_we_i) owner_d = OWN_DBG;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) owner_q <= OWN_NONE;
    else         owner_q <= owner_d;
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
  assign cpu_rvalid_o = (owner_q == OWN_CPU);
  assign dbg_rvalid_o = (owner_q == OWN_DBG);
  assign cpu_rdata_o  = mem_rdata_i;
  assign dbg_rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LIM = 4;

  logic          clk, rst_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port memory (environment, not the reference model).
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model: debug wins only after LIM consecutive denied cycles.
  int          m_starve;
  logic [DW-1:0] m_mem [16];
  bit          m_known [16];
  int          m_pend;          // 0 none, 1 cpu, 2 dbg
  logic [DW-1:0] m_pdata;
  bit          m_pknown;

  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; drive_idle();
    step();
    rst_n = 1;
    m_starve = 0; m_pend = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd1; cpu_wdata = 16'h1111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd2; dbg_wdata = 16'h2222;
    @(negedge clk);
    n_chk++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt got=%0b exp=0", cpu_gnt); else n_pass++;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL rst_dbg_gnt got=%0b exp=0", dbg_gnt); else n_pass++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%0b exp=0", mem_we); else n_pass++;
    n_chk++; if (cpu_stall !== 1'b1) $display("FAIL rst_stall got=%0b exp=1", cpu_stall); else n_pass++;
    n_chk++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {cpu_rvalid, dbg_rvalid}); else n_pass++;
    step();
    rst_n = 1; #1;
    n_chk++; if (cpu_gnt !== 1'b1) $display("FAIL rel_cpu_gnt got=%0b exp=1", cpu_gnt); else n_pass++;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL rel_dbg_gnt got=%0b exp=0", dbg_gnt); else n_pass++;
    n_chk++; if (mem_addr !== 4'd1 || mem_we !== 1'b1) $display("FAIL rel_mem got=%0h/%0b exp=1/1", mem_addr, mem_we); else n_pass++;
    step(); drive_idle(); step();
  endtask

  task automatic test_write_read();
    apply_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    n_chk++; if (mem_we !== 1'b1 || mem_wdata !== 16'hBEEF) $display("FAIL wr_mem got=%0b/%0h exp=1/beef", mem_we, mem_wdata); else n_pass++;
    step();
    cpu_we = 0;
    @(negedge clk);
    n_chk++; if (cpu_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got=%0b exp=0", cpu_rvalid); else n_pass++;
    n_chk++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) $display("FAIL rd_gnt got=%0b/%0b exp=1/0", cpu_gnt, mem_we); else n_pass++;
    step(); drive_idle();
    @(negedge clk);
    n_chk++; if (cpu_rvalid !== 1'b1) $display("FAIL rd_rvalid got=%0b exp=1", cpu_rvalid); else n_pass++;
    n_chk++; if (cpu_rdata !== 16'hBEEF) $display("FAIL rd_data got=%0h exp=beef", cpu_rdata); else n_pass++;
    n_chk++; if (dbg_rvalid !== 1'b0) $display("FAIL rd_dbg_rvalid got=%0b exp=0", dbg_rvalid); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (cpu_rvalid !== 1'b0) $display("FAIL rd_rvalid_drop got=%0b exp=0", cpu_rvalid); else n_pass++;
    step();
  endtask

  task automatic test_contention();
    bit e;
    apply_reset();
    cpu_req = 1; dbg_req = 1; cpu_addr = 4'd5; dbg_addr = 4'd6;
    for (int k = 1; k <= 15; k++) begin
      e = (k % (LIM + 1) == 0);
      @(negedge clk);
      n_chk++; if (cpu_gnt !== !e || dbg_gnt !== e || cpu_stall !== e)
        $display("FAIL cont_c%0d got=gnt%0b%0b stall%0b exp=gnt%0b%0b stall%0b", k, cpu_gnt, dbg_gnt, cpu_stall, !e, e, e);
      else n_pass++;
      step();
    end
    drive_idle(); step();
  endtask

  task automatic test_debug_only();
    apply_reset();
    dbg_req = 1; dbg_we = 0;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) dbg_addr = k[AW-1:0]; else dbg_req = 0;
      @(negedge clk);
      n_chk++; if (dbg_gnt !== (k < 16)) $display("FAIL dbgonly_gnt_c%0d got=%0b exp=%0b", k, dbg_gnt, k < 16); else n_pass++;
      n_chk++; if (dbg_rvalid !== (k >= 1 && k <= 16) || cpu_rvalid !== 1'b0)
        $display("FAIL dbgonly_rvalid_c%0d got=%0b%0b exp=0%0b", k, cpu_rvalid, dbg_rvalid, (k >= 1 && k <= 16));
      else n_pass++;
      if (k == 4) begin
        n_chk++; if (dbg_rdata !== 16'hBEEF) $display("FAIL dbgonly_data got=%0h exp=beef", dbg_rdata); else n_pass++;
      end
      step();
    end
    // Counter stayed clear: CPU must win a full LIM cycles.
    cpu_req = 1; dbg_req = 1;
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      n_chk++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) $display("FAIL dbgonly_cnt_c%0d got=%0b%0b exp=10", k, cpu_gnt, dbg_gnt); else n_pass++;
      step();
    end
    drive_idle(); step();
  endtask

  task automatic test_withdraw();
    apply_reset();
    cpu_req = 1; dbg_req = 1;
    for (int k = 1; k <= LIM; k++) step();
    dbg_req = 0;
    @(negedge clk);
    n_chk++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0)
      $display("FAIL wd_drop got=gnt%0b%0b stall%0b exp=gnt10 stall0", cpu_gnt, dbg_gnt, cpu_stall);
    else n_pass++;
    step();
    dbg_req = 1;
    @(negedge clk);
    n_chk++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) $display("FAIL wd_cpu_pri got=%0b%0b exp=10", cpu_gnt, dbg_gnt); else n_pass++;
    step(); drive_idle(); step();
  endtask

  task automatic test_async_reset();
    bit e;
    apply_reset();
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    @(negedge clk);
    n_chk++; if (dbg_gnt !== 1'b1) $display("FAIL ar_dbg_gnt got=%0b exp=1", dbg_gnt); else n_pass++;
    #2 rst_n = 0; #1;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL ar_gnt_forced got=%0b exp=0", dbg_gnt); else n_pass++;
    step();
    rst_n = 1; drive_idle();
    @(negedge clk);
    n_chk++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL ar_rvalid got=%0b%0b exp=00", cpu_rvalid, dbg_rvalid); else n_pass++;
    step();
    // Partial starvation count must be cleared by reset.
    cpu_req = 1; dbg_req = 1;
    for (int k = 1; k <= 3; k++) step();
    @(negedge clk); rst_n = 0;
    step(); rst_n = 1;
    for (int k = 1; k <= LIM + 1; k++) begin
      e = (k == LIM + 1);
      @(negedge clk);
      n_chk++; if (dbg_gnt !== e || cpu_gnt !== !e) $display("FAIL ar_cnt_c%0d got=%0b%0b exp=%0b%0b", k, cpu_gnt, dbg_gnt, !e, e); else n_pass++;
      step();
    end
    drive_idle(); step();
  endtask

  task automatic test_random();
    bit hold_c = 0, hold_d = 0, e_c, e_d, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    apply_reset();
    for (int i = 0; i < 16; i++) m_known[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold_c) begin
        cpu_req = ($urandom_range(0, 9) < 7); cpu_we = $urandom_range(0, 1);
        cpu_addr = $urandom_range(0, 15); cpu_wdata = $urandom_range(0, 16'hFFFF);
      end
      if (!hold_d) begin
        dbg_req = ($urandom_range(0, 9) < 5); dbg_we = $urandom_range(0, 1);
        dbg_addr = $urandom_range(0, 15); dbg_wdata = $urandom_range(0, 16'hFFFF);
      end
      e_c = cpu_req && !(m_starve >= LIM && dbg_req);
      e_d = dbg_req && !e_c;
      e_we = e_c ? cpu_we : (e_d ? dbg_we : 1'b0);
      e_a  = e_c ? cpu_addr : (e_d ? dbg_addr : '0);
      e_wd = e_c ? cpu_wdata : (e_d ? dbg_wdata : '0);
      @(negedge clk);
      n_chk++; if (cpu_gnt !== e_c || dbg_gnt !== e_d || cpu_stall !== (cpu_req && !e_c))
        $display("FAIL rnd_gnt n=%0d got=gnt%0b%0b stall%0b exp=gnt%0b%0b stall%0b", n, cpu_gnt, dbg_gnt, cpu_stall, e_c, e_d, cpu_req && !e_c);
      else n_pass++;
      n_chk++; if (mem_we !== e_we || mem_addr !== e_a || mem_wdata !== e_wd)
        $display("FAIL rnd_mem n=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", n, mem_we, mem_addr, mem_wdata, e_we, e_a, e_wd);
      else n_pass++;
      n_chk++; if (cpu_rvalid !== (m_pend == 1) || dbg_rvalid !== (m_pend == 2))
        $display("FAIL rnd_rvalid n=%0d got=%0b%0b exp=%0b%0b", n, cpu_rvalid, dbg_rvalid, m_pend == 1, m_pend == 2);
      else n_pass++;
      if (m_pend != 0 && m_pknown) begin
        n_chk++; if ((m_pend == 1 ? cpu_rdata : dbg_rdata) !== m_pdata)
          $display("FAIL rnd_rdata n=%0d got=%0h exp=%0h", n, (m_pend == 1 ? cpu_rdata : dbg_rdata), m_pdata);
        else n_pass++;
      end
      @(posedge clk);
      if (e_c || e_d) begin
        if (e_we) begin
          m_mem[e_a] = e_wd; m_known[e_a] = 1; m_pend = 0;
        end else begin
          m_pend = e_c ? 1 : 2; m_pdata = m_mem[e_a]; m_pknown = m_known[e_a];
        end
      end else m_pend = 0;
      if (dbg_req && !e_d) m_starve++; else m_starve = 0;
      hold_c = cpu_req && !e_c;
      hold_d = dbg_req && !e_d;
      #1;
    end
    drive_idle(); step();
  endtask

  initial begin
    rst_n = 0; drive_idle();
    m_starve = 0; m_pend = 0; m_pdata = '0; m_pknown = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_contention();
    test_debug_only();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port 16-entry data memory between the pipeline's memory stage and a debug/loader port. Each cycle at most one requester reaches the memory. The memory stage has priority, and a starvation counter guarantees the debug port forward progress. The block sits between the memory stage and the data memory, and raises a stall to the pipeline hazard logic whenever the memory stage is not granted.

## Interface
- DATA_W, 16, memory word width
- ADDR_W, 4, memory address width (16 words)
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced priority (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  memory-stage access request (one access per cycle while high)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  memory-stage address
- cpu_wdata  in  DATA_W  memory-stage write data
- cpu_gnt  out  1  memory-stage access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; pipeline holds M stage
- cpu_rvalid  out  1  read data for memory stage valid this cycle
- cpu_rdata  out  DATA_W  read data to memory stage
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port request, same meaning as cpu_*
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  read data for debug port valid this cycle
- dbg_rdata  out  DATA_W  read data to debug port
- mem_we  out  1  write enable to data memory
- mem_addr  out  ADDR_W  address to data memory
- mem_wdata  out  DATA_W  write data to data memory
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address

## Operation
- Priority state register `pri`: CPU_PRI (reset) or DBG_PRI.
- Grant (combinational, one-hot or zero):
  - In CPU_PRI: cpu_gnt = cpu_req; dbg_gnt = dbg_req & ~cpu_req.
  - In DBG_PRI: dbg_gnt = dbg_req; cpu_gnt = cpu_req & ~dbg_req.
- Memory drive: mem_addr, mem_wdata and mem_we come from the granted requester. mem_we = granted_we & (cpu_gnt | dbg_gnt). With no grant, mem_we = 0 and addr/wdata are don't-care (drive 0).
- Starvation counter `wait_cnt` (width clog2(STARVE_LIMIT+1)):
  - Clears when dbg_gnt = 1 or dbg_req = 0.
  - Otherwise, if dbg_req & ~dbg_gnt, increments and saturates at STARVE_LIMIT.
- Priority transitions, evaluated at the clock edge:
  - CPU_PRI → DBG_PRI when the next-state wait_cnt equals STARVE_LIMIT.
  - DBG_PRI → CPU_PRI when dbg_gnt = 1, or when dbg_req = 0 (request withdrawn).
- Read return:
  - Registered `rd_owner` = {cpu, dbg, none}, set each cycle from the granted read (gnt & ~we). Writes and idle cycles set none.
  - Next cycle: cpu_rvalid = (rd_owner == cpu) and dbg_rvalid = (rd_owner == dbg). Both are registered flops.
  - cpu_rdata = dbg_rdata = mem_rdata, routed unconditionally. Consumers qualify with rvalid.
- cpu_stall = cpu_req & ~cpu_gnt. A stalled CPU request must hold its req/we/addr/wdata stable; the debug port must do the same.

## Timing
- Grant and memory drive: zero latency, same cycle as the request.
- Read data: returned exactly 1 cycle after the grant. Back-to-back grants are fully pipelined, one access per cycle, no bubbles.
- Write: committed at the edge ending the grant cycle.
- Debug worst-case wait under continuous cpu_req: STARVE_LIMIT denied cycles. Debug is granted in cycle STARVE_LIMIT+1, and the CPU stalls exactly that one cycle.
- Reset (reset = 0, asynchronous):
  - pri = CPU_PRI, wait_cnt = 0, rd_owner = none.
  - cpu_rvalid = dbg_rvalid = 0.
  - cpu_gnt, dbg_gnt and mem_we are forced to 0, and cpu_stall = cpu_req, while reset is low.
- Reset asserted mid-read: the pending rvalid is dropped and never issued.
- Simultaneous cpu/dbg requests to the same address: serialized per priority. The second requester sees the first's write.
- STARVE_LIMIT reached while cpu_req = 0: debug is already granted, so the counter clears and there is no state change.

## Structure
- Shared CPU package: DATA_W/ADDR_W constants, the `pri_t` enum {CPU_PRI, DBG_PRI}, and the `owner_t` enum {OWN_NONE, OWN_CPU, OWN_DBG}.
- Single flat module. A sub-module is not warranted. The starvation counter plus priority FSM is one always block, the read-owner tracking another.
- The memory stage instantiates this block between itself and the data memory. The stall feeds the hazard unit.

## Test plan
- Reset: hold reset = 0 with cpu_req = dbg_req = 1 → both gnt = 0, mem_we = 0, cpu_stall = 1. Release reset → cpu_gnt = 1 in the first cycle.
- CPU write then read: write 0xBEEF to addr 3, read addr 3 next cycle → cpu_rvalid = 1 with cpu_rdata = 0xBEEF one cycle after the read grant; dbg_rvalid = 0.
- Contention: cpu_req and dbg_req high continuously, STARVE_LIMIT = 4 → cpu_gnt for cycles 1–4, dbg_gnt with cpu_stall = 1 in cycle 5, then cpu_gnt resumes. The pattern repeats every 5 cycles.
- Debug only: dbg reads addrs 0..15 back-to-back with cpu_req = 0 → 16 consecutive dbg_rvalid pulses, each 1 cycle late; wait_cnt stays 0.
- Withdrawal: dbg_req dropped after 4 denied cycles (pri = DBG_PRI) → pri returns to CPU_PRI next edge, with no CPU stall.
- Async reset mid-read: assert reset during a dbg read grant cycle → no dbg_rvalid afterwards, all state at reset values.
